// File: rtl/instr_encoder_if.sv
// Instruction encoder bus: field-tuple input handshake plus the IMEM write port.
//
// Handshake rules (both channels):
//   - Field tuple: a tuple transfers on a rising clk edge where in_valid && in_ready.
//     in_ready never depends on in_valid.
//   - IMEM write: a write completes on a rising clk edge where mem_we && mem_ready.
//     While mem_we is high and mem_ready is low, mem_addr and mem_wdata stay stable.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_opcode;
  logic [2:0]        in_rx;
  logic [2:0]        in_ry;
  logic [2:0]        in_rz;
  logic [2:0]        in_func;
  logic [10:0]       in_kk;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ready;

  // Producer of tuples and consumer of IMEM writes (loader or test harness).
  modport master (
    output in_valid, in_opcode, in_rx, in_ry, in_rz, in_func, in_kk, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // The encoder itself.
  modport slave (
    input  in_valid, in_opcode, in_rx, in_ry, in_rz, in_func, in_kk, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 16-bit instruction words and streams
// them into IMEM at consecutive addresses. Inverse of the field decoder.
// One output register stage: a tuple accepted on cycle N is presented on N+1.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int STRICT = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              range_err,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W:0]   word_count,
  output logic              full
);

  // Number of words IMEM can hold; word_count reaching this value means full.
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  logic              mem_we_q;
  logic [15:0]       mem_wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       enc_word;
  logic              kk_ok;
  logic              accept;
  logic              done;
  logic              write_word;

  // Input may only be taken when the output register is free or draining this cycle.
  assign bus.in_ready  = !full && !start && (!mem_we_q || bus.mem_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign done          = mem_we_q && bus.mem_ready;
  // Out-of-range kk words are dropped in strict mode, truncated otherwise.
  assign write_word    = kk_ok || (STRICT == 0);

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_addr  = addr_q;

  // Field packing per opcode and kk range check.
  always_comb begin
    enc_word = 16'h0000;
    kk_ok    = 1'b1;
    case (bus.in_opcode)
      2'd0: begin
        enc_word = {2'b00, bus.in_ry, bus.in_rx, bus.in_func, bus.in_rz, 2'b00};
      end
      2'd1: begin
        enc_word = {bus.in_kk[4:0], bus.in_rx, bus.in_func, bus.in_rz, 2'b01};
        kk_ok    = (bus.in_kk[10:5] == 6'd0);
      end
      2'd2: begin
        enc_word = {bus.in_kk, bus.in_rz, 2'b10};
      end
      default: begin
        enc_word = {bus.in_kk[7:6], bus.in_ry, bus.in_rx, bus.in_kk[5:0], 2'b11};
        kk_ok    = (bus.in_kk[10:8] == 3'd0);
      end
    endcase
  end

  // Output register: load on accept, release on completed write, dropped by start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 16'h0000;
      range_err   <= 1'b0;
    end else if (start) begin
      mem_we_q    <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      range_err <= accept && !kk_ok;
      if (accept && write_word) begin
        mem_we_q    <= 1'b1;
        mem_wdata_q <= enc_word;
      end else if (done) begin
        mem_we_q    <= 1'b0;
      end
    end
  end

  // Write address, word count and full flag advance only on completed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      word_count <= '0;
      full       <= 1'b0;
    end else if (start) begin
      addr_q     <= '0;
      word_count <= '0;
      full       <= 1'b0;
    end else if (done) begin
      addr_q     <= addr_q + 1'b1;
      word_count <= word_count + 1'b1;
      if (word_count + 1'b1 == CAPACITY) begin
        full <= 1'b1;
      end
    end
  end

  // Saturating count of range errors seen on accepted tuples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (start) begin
      err_count <= '0;
    end else if (accept && !kk_ok && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder. dut_a: ADDR_W=8, STRICT=1, ERR_W=2.
// dut_b: ADDR_W=2, STRICT=0, ERR_W=8 (fill/wrap and truncation).
module tb_instr_encoder;

  logic clk;
  logic rst_n;
  logic start_a;
  logic start_b;

  logic        range_err_a;
  logic [1:0]  err_count_a;
  logic [8:0]  word_count_a;
  logic        full_a;
  logic        range_err_b;
  logic [7:0]  err_count_b;
  logic [2:0]  word_count_b;
  logic        full_b;

  int check_count = 0;
  int pass_count  = 0;

  instr_encoder_if #(.ADDR_W(8)) ia ();
  instr_encoder_if #(.ADDR_W(2)) ib ();

  instr_encoder #(.ADDR_W(8), .STRICT(1), .ERR_W(2)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_a),
    .bus        (ia),
    .range_err  (range_err_a),
    .err_count  (err_count_a),
    .word_count (word_count_a),
    .full       (full_a)
  );

  instr_encoder #(.ADDR_W(2), .STRICT(0), .ERR_W(8)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_b),
    .bus        (ib),
    .range_err  (range_err_b),
    .err_count  (err_count_b),
    .word_count (word_count_b),
    .full       (full_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [2:0] rz, input logic [2:0] func, input logic [10:0] kk);
    ia.in_opcode = op; ia.in_rx = rx; ia.in_ry = ry; ia.in_rz = rz;
    ia.in_func = func; ia.in_kk = kk; ia.in_valid = 1'b1;
  endtask

  task automatic drive_b(input logic [1:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [2:0] rz, input logic [2:0] func, input logic [10:0] kk);
    ib.in_opcode = op; ib.in_rx = rx; ib.in_ry = ry; ib.in_rz = rz;
    ib.in_func = func; ib.in_kk = kk; ib.in_valid = 1'b1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // Directed sequence
  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ia.in_valid = 1'b0; ia.mem_ready = 1'b1;
    ib.in_valid = 1'b0; ib.mem_ready = 1'b1;
    drive_a(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 11'd0); ia.in_valid = 1'b0;
    drive_b(2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 11'd0); ib.in_valid = 1'b0;
    repeat (2) tick();

    check("rst_mem_we", 32'(ia.mem_we), 32'd0);
    check("rst_mem_addr", 32'(ia.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(ia.mem_wdata), 32'd0);
    check("rst_range_err", 32'(range_err_a), 32'd0);
    check("rst_err_count", 32'(err_count_a), 32'd0);
    check("rst_word_count", 32'(word_count_a), 32'd0);
    check("rst_full", 32'(full_a), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(ia.in_ready), 32'd1);

    // op0 packing, one cycle latency
    drive_a(2'd0, 3'd1, 3'd2, 3'd3, 3'd4, 11'd0);
    tick();
    ia.in_valid = 1'b0;
    check("op0_we", 32'(ia.mem_we), 32'd1);
    check("op0_addr", 32'(ia.mem_addr), 32'd0);
    check("op0_wdata", 32'(ia.mem_wdata), 32'h118C);
    tick();
    check("op0_done_we", 32'(ia.mem_we), 32'd0);
    check("op0_done_count", 32'(word_count_a), 32'd1);
    check("op0_done_addr", 32'(ia.mem_addr), 32'd1);

    // start clears address and count
    start_a = 1'b1;
    #1;
    check("start_blocks_ready", 32'(ia.in_ready), 32'd0);
    tick();
    start_a = 1'b0;
    check("start_addr", 32'(ia.mem_addr), 32'd0);
    check("start_count", 32'(word_count_a), 32'd0);

    // op2, op1, op3 back to back, then an illegal op1
    drive_a(2'd2, 3'd0, 3'd0, 3'd5, 3'd0, 11'h7FF);
    tick();
    check("op2_wdata", 32'(ia.mem_wdata), 32'hFFF6);
    check("op2_addr", 32'(ia.mem_addr), 32'd0);
    drive_a(2'd1, 3'd7, 3'd0, 3'd0, 3'd0, 11'h01F);
    tick();
    check("op1_wdata", 32'(ia.mem_wdata), 32'hFF01);
    check("op1_addr", 32'(ia.mem_addr), 32'd1);
    check("op1_we", 32'(ia.mem_we), 32'd1);
    drive_a(2'd3, 3'd2, 3'd3, 3'd0, 3'd0, 11'h0A5);
    tick();
    check("op3_wdata", 32'(ia.mem_wdata), 32'h9A97);
    check("op3_addr", 32'(ia.mem_addr), 32'd2);
    drive_a(2'd1, 3'd0, 3'd0, 3'd0, 3'd0, 11'h020);
    tick();
    ia.in_valid = 1'b0;
    check("strict_no_we", 32'(ia.mem_we), 32'd0);
    check("strict_range_err", 32'(range_err_a), 32'd1);
    check("strict_err_count", 32'(err_count_a), 32'd1);
    check("strict_addr", 32'(ia.mem_addr), 32'd3);
    tick();
    check("range_err_pulse", 32'(range_err_a), 32'd0);
    check("strict_addr_hold", 32'(ia.mem_addr), 32'd3);
    check("strict_count", 32'(word_count_a), 32'd3);

    // err_count saturation at 2'b11
    drive_a(2'd3, 3'd0, 3'd0, 3'd0, 3'd0, 11'h100);
    tick();
    check("sat_err2", 32'(err_count_a), 32'd2);
    drive_a(2'd1, 3'd0, 3'd0, 3'd0, 3'd0, 11'h040);
    tick();
    check("sat_err3", 32'(err_count_a), 32'd3);
    drive_a(2'd1, 3'd0, 3'd0, 3'd0, 3'd0, 11'h7E0);
    tick();
    ia.in_valid = 1'b0;
    check("sat_hold", 32'(err_count_a), 32'd3);
    check("sat_range_err", 32'(range_err_a), 32'd1);
    check("sat_we", 32'(ia.mem_we), 32'd0);
    tick();

    // Backpressure: mem_ready low for 3 cycles
    ia.mem_ready = 1'b0;
    drive_a(2'd0, 3'd5, 3'd6, 3'd7, 3'd1, 11'd0);
    tick();
    drive_a(2'd2, 3'd0, 3'd0, 3'd0, 3'd0, 11'd0);
    for (int i = 0; i < 3; i++) begin
      check("stall_we", 32'(ia.mem_we), 32'd1);
      check("stall_addr", 32'(ia.mem_addr), 32'd3);
      check("stall_wdata", 32'(ia.mem_wdata), 32'h353C);
      check("stall_ready", 32'(ia.in_ready), 32'd0);
      tick();
    end
    ia.mem_ready = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    check("release_count", 32'(word_count_a), 32'd4);
    check("release_addr", 32'(ia.mem_addr), 32'd4);
    check("release_wdata", 32'(ia.mem_wdata), 32'h0002);
    tick();
    check("release_done_count", 32'(word_count_a), 32'd5);
    check("release_done_we", 32'(ia.mem_we), 32'd0);

    // Small memory: fill, wrap, full, start; STRICT=0 truncation
    drive_b(2'd1, 3'd0, 3'd0, 3'd0, 3'd0, 11'h025);
    tick();
    check("trunc_wdata", 32'(ib.mem_wdata), 32'h2801);
    check("trunc_we", 32'(ib.mem_we), 32'd1);
    check("trunc_range_err", 32'(range_err_b), 32'd1);
    check("trunc_err_count", 32'(err_count_b), 32'd1);
    drive_b(2'd2, 3'd0, 3'd0, 3'd1, 3'd0, 11'h001);
    tick();
    check("fill_wdata", 32'(ib.mem_wdata), 32'h0026);
    check("fill_addr1", 32'(ib.mem_addr), 32'd1);
    tick();
    check("fill_addr2", 32'(ib.mem_addr), 32'd2);
    tick();
    ib.in_valid = 1'b0;
    check("fill_addr3", 32'(ib.mem_addr), 32'd3);
    check("fill_count3", 32'(word_count_b), 32'd3);
    check("fill_not_full", 32'(full_b), 32'd0);
    tick();
    check("full_set", 32'(full_b), 32'd1);
    check("full_ready", 32'(ib.in_ready), 32'd0);
    check("full_wrap_addr", 32'(ib.mem_addr), 32'd0);
    check("full_count", 32'(word_count_b), 32'd4);
    ib.in_valid = 1'b1;
    tick();
    check("full_blocks", 32'(ib.mem_we), 32'd0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("restart_full", 32'(full_b), 32'd0);
    check("restart_count", 32'(word_count_b), 32'd0);
    check("restart_err", 32'(err_count_b), 32'd0);
    tick();
    ib.in_valid = 1'b0;
    check("restart_we", 32'(ib.mem_we), 32'd1);
    check("restart_addr", 32'(ib.mem_addr), 32'd0);
    tick();
    check("restart_count1", 32'(word_count_b), 32'd1);

    // Asynchronous reset during a stalled write
    ia.mem_ready = 1'b0;
    drive_a(2'd0, 3'd1, 3'd1, 3'd1, 3'd1, 11'd0);
    tick();
    ia.in_valid = 1'b0;
    check("pre_rst_we", 32'(ia.mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(ia.mem_we), 32'd0);
    check("async_rst_addr", 32'(ia.mem_addr), 32'd0);
    check("async_rst_wdata", 32'(ia.mem_wdata), 32'd0);
    check("async_rst_count", 32'(word_count_a), 32'd0);
    check("async_rst_err", 32'(err_count_a), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(ia.in_ready), 32'd1);

    // start drops a pending write and refuses input
    drive_a(2'd2, 3'd0, 3'd0, 3'd0, 3'd0, 11'h003);
    tick();
    check("pend_we", 32'(ia.mem_we), 32'd1);
    drive_a(2'd0, 3'd2, 3'd2, 3'd2, 3'd2, 11'd0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    ia.in_valid = 1'b0;
    check("start_drop_we", 32'(ia.mem_we), 32'd0);
    check("start_drop_count", 32'(word_count_a), 32'd0);
    ia.mem_ready = 1'b1;
    repeat (2) tick();
    check("start_drop_never", 32'(word_count_a), 32'd0);
    check("start_drop_addr", 32'(ia.mem_addr), 32'd0);
    check("start_drop_idle", 32'(ia.mem_we), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
